// File: rtl/reg_file_rd.sv
// reg_file_rd: 2R/1W register file with a registered valid/ready read stage.
// Define REGFILE_BYPASS_EN for write-first capture on same-edge write/read hazards.
module reg_file_rd #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          Clk,
  input  logic          Clr,
  input  logic          We,
  input  logic [AW-1:0] Wa,
  input  logic [DW-1:0] Wd,
  input  logic          Rreq,
  input  logic [AW-1:0] Ra1,
  input  logic [AW-1:0] Ra2,
  output logic          Rack,
  output logic          Rvalid,
  input  logic          Rrdy,
  output logic [DW-1:0] Rd1,
  output logic [DW-1:0] Rd2
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata1;
  logic [DW-1:0] rdata2;
  logic          wr_en;

  assign wr_en = We && (Wa != '0);

  // Handshake depends only on control, never on addresses or data
  assign Rack = Rreq & (~Rvalid | Rrdy) & ~Clr;

  always_ff @(posedge Clk) begin
    if (Clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[Wa] <= Wd;
    end
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (Ra1 != '0) begin
      rdata1 = mem[Ra1];
    end
    if (Ra2 != '0) begin
      rdata2 = mem[Ra2];
    end
`ifdef REGFILE_BYPASS_EN
    // wr_en already excludes address 0
    if (wr_en && (Wa == Ra1)) begin
      rdata1 = Wd;
    end
    if (wr_en && (Wa == Ra2)) begin
      rdata2 = Wd;
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      Rvalid <= 1'b0;
      Rd1    <= '0;
      Rd2    <= '0;
    end else if (Rack) begin
      Rvalid <= 1'b1;
      Rd1    <= rdata1;
      Rd2    <= rdata2;
    end else if (Rvalid && Rrdy) begin
      Rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_file_rd.sv
// tb_reg_file_rd: directed and randomized checks of reg_file_rd
// against an array-based reference model.
module tb_reg_file_rd;

  logic        Clk;
  logic        Clr;
  logic        We;
  logic [4:0]  Wa;
  logic [31:0] Wd;
  logic        Rreq;
  logic [4:0]  Ra1;
  logic [4:0]  Ra2;
  logic        Rack;
  logic        Rvalid;
  logic        Rrdy;
  logic [31:0] Rd1;
  logic [31:0] Rd2;

  int checks = 0;
  int failures = 0;

  logic [31:0] mm [32];
  logic        mv;
  logic [31:0] m1;
  logic [31:0] m2;

  reg_file_rd #(.DW(32), .AW(5)) dut (
    .Clk(Clk), .Clr(Clr), .We(We), .Wa(Wa), .Wd(Wd),
    .Rreq(Rreq), .Ra1(Ra1), .Ra2(Ra2), .Rack(Rack),
    .Rvalid(Rvalid), .Rrdy(Rrdy), .Rd1(Rd1), .Rd2(Rd2)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (We && Wa == a) return Wd;
`endif
    return mm[a];
  endfunction

  task automatic model_edge();
    logic acc;
    if (Clr) begin
      for (int i = 0; i < 32; i++) mm[i] = 32'h0;
      mv = 1'b0;
      m1 = 32'h0;
      m2 = 32'h0;
    end else begin
      acc = Rreq && (!mv || Rrdy);
      if (acc) begin
        m1 = mread(Ra1);
        m2 = mread(Ra2);
        mv = 1'b1;
      end else if (mv && Rrdy) begin
        mv = 1'b0;
      end
      if (We && Wa != 5'd0) mm[Wa] = Wd;
    end
  endtask

  task automatic tick();
    logic er;
    @(negedge Clk);
    er = !Clr && Rreq && (!mv || Rrdy);
    chk("rack", 32'(Rack), 32'(er));
    @(posedge Clk);
    model_edge();
    #1;
    chk("rvalid", 32'(Rvalid), 32'(mv));
    chk("rd1", Rd1, m1);
    chk("rd2", Rd2, m2);
  endtask

  task automatic idle();
    We = 1'b0; Wa = '0; Wd = '0;
    Rreq = 1'b0; Ra1 = '0; Ra2 = '0;
  endtask

  initial begin
    logic [31:0] hz;
    for (int i = 0; i < 32; i++) mm[i] = 32'h0;
    mv = 1'b0; m1 = 32'h0; m2 = 32'h0;
    Clr = 1'b1; Rrdy = 1'b0;
    idle();
    tick();
    Rreq = 1'b1; Ra1 = 5'd3;
    tick();
    chk("reset_rvalid", 32'(Rvalid), 32'h0);

    // zero register
    Clr = 1'b0; Rrdy = 1'b1;
    Rreq = 1'b1; Ra1 = 5'd0; Ra2 = 5'd31;
    tick();
    chk("zr_valid", 32'(Rvalid), 32'h1);
    chk("zr_rd1", Rd1, 32'h0);
    chk("zr_rd2", Rd2, 32'h0);
    idle(); We = 1'b1; Wa = 5'd0; Wd = 32'hFFFF_FFFF;
    tick();
    idle(); Rreq = 1'b1; Ra1 = 5'd0;
    tick();
    chk("zr_write_rd1", Rd1, 32'h0);

    // write then read
    idle(); We = 1'b1; Wa = 5'd5; Wd = 32'hDEAD_BEEF;
    tick();
    Wa = 5'd6; Wd = 32'h1234_5678;
    tick();
    idle(); Rreq = 1'b1; Ra1 = 5'd5; Ra2 = 5'd6;
    tick();
    chk("wr_rd1", Rd1, 32'hDEAD_BEEF);
    chk("wr_rd2", Rd2, 32'h1234_5678);

    // same-edge hazard
    idle(); We = 1'b1; Wa = 5'd7; Wd = 32'h1;
    tick();
    Wd = 32'hA5A5_A5A5; Rreq = 1'b1; Ra1 = 5'd7; Ra2 = 5'd7;
    tick();
`ifdef REGFILE_BYPASS_EN
    hz = 32'hA5A5_A5A5;
`else
    hz = 32'h1;
`endif
    chk("hazard_rd1", Rd1, hz);
    chk("hazard_rd2", Rd2, hz);
    idle(); Rreq = 1'b1; Ra1 = 5'd7;
    tick();
    chk("hazard_stored", Rd1, 32'hA5A5_A5A5);

    // stall with snapshot semantics
    idle(); We = 1'b1; Wa = 5'd10; Wd = 32'h11;
    tick();
    idle(); Rreq = 1'b1; Ra1 = 5'd10;
    tick();
    chk("stall_pre", Rd1, 32'h11);
    Rrdy = 1'b0; We = 1'b1; Wa = 5'd10; Wd = 32'h22;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_rack", 32'(Rack), 32'h0);
      chk("stall_rd1", Rd1, 32'h11);
      chk("stall_valid", 32'(Rvalid), 32'h1);
    end
    We = 1'b0; Rrdy = 1'b1;
    #1;
    chk("stall_release_rack", 32'(Rack), 32'h1);
    tick();
    chk("stall_new_rd1", Rd1, 32'h22);
    chk("stall_new_valid", 32'(Rvalid), 32'h1);

    // streaming
    idle();
    for (int i = 1; i <= 8; i++) begin
      We = 1'b1; Wa = 5'(i); Wd = 32'(i * 3);
      tick();
    end
    idle(); Rreq = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      Ra1 = 5'(i);
      tick();
      chk("stream_valid", 32'(Rvalid), 32'h1);
      chk("stream_rd1", Rd1, 32'(i * 3));
    end

    // reset while a result is held
    idle(); We = 1'b1; Wa = 5'd9; Wd = 32'h99;
    tick();
    idle(); Rreq = 1'b1; Ra1 = 5'd9; Ra2 = 5'd9;
    tick();
    chk("mid_pre", Rd1, 32'h99);
    Rrdy = 1'b0; Rreq = 1'b0;
    tick();
    Clr = 1'b1;
    tick();
    chk("mid_valid", 32'(Rvalid), 32'h0);
    chk("mid_rd1", Rd1, 32'h0);
    chk("mid_rd2", Rd2, 32'h0);
    Clr = 1'b0;
    tick();
    chk("mid_no_repres", 32'(Rvalid), 32'h0);
    Rreq = 1'b1; Ra1 = 5'd9; Rrdy = 1'b1;
    tick();
    chk("mid_rd9", Rd1, 32'h0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      Clr  = ($urandom_range(0, 39) == 0);
      We   = $urandom_range(0, 1) == 1;
      Wd   = $urandom;
      Rreq = $urandom_range(0, 3) != 0;
      Ra1  = 5'($urandom_range(0, 31));
      Ra2  = 5'($urandom_range(0, 31));
      Rrdy = $urandom_range(0, 2) != 0;
      Wa   = ($urandom_range(0, 2) == 0) ? Ra1 : 5'($urandom_range(0, 31));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
